// File: rtl/avaliador_tentativa.sv
// Guess evaluator for the password game: classifies each accepted guess as equal,
// near or wrong, counts misses, latches a win and locks out after MAX_TENT misses.
module avaliador_tentativa #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TOL      = 3,
    parameter int unsigned MAX_TENT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] senha,
    input  logic [WIDTH-1:0] tentativa,
    input  logic             enviar,
    input  logic             novo_jogo,
    output logic             pronto,
    output logic             valido,
    output logic             igual,
    output logic             perto,
    output logic             errada,
    output logic             acima,
    output logic [WIDTH-1:0] distancia,
    output logic [7:0]       erros,
    output logic             vitoria,
    output logic             bloqueado
);

    localparam int unsigned DW = WIDTH + 1;

    localparam logic [1:0] OCIOSO    = 2'd0;
    localparam logic [1:0] CALCULA   = 2'd1;
    localparam logic [1:0] RESULTADO = 2'd2;
    localparam logic [1:0] FIM       = 2'd3;

    localparam logic [WIDTH-1:0] TOL_W = WIDTH'(TOL);
    localparam logic [7:0]       MAX_W = 8'(MAX_TENT);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] senha_r;
    logic [WIDTH-1:0] tent_r;
    logic [DW-1:0]    diff;
    logic [WIDTH-1:0] mag;
    logic             positivo;
    logic             acerto;
    logic             proximo;
    logic [7:0]       erros_inc;

    // Signed difference in WIDTH+1 bits so the extreme operands never wrap.
    always_comb begin
        diff      = {1'b0, tent_r} - {1'b0, senha_r};
        mag       = diff[DW-1] ? WIDTH'(-diff) : diff[WIDTH-1:0];
        positivo  = !diff[DW-1] && (diff != '0);
        acerto    = (distancia == '0);
        proximo   = !acerto && (distancia <= TOL_W);
        erros_inc = erros + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OCIOSO;
        end else begin
            state <= state_next;
        end
    end

    // RESULTADO spans two cycles: the first loads the verdict, the second (valido high) leaves.
    always_comb begin
        state_next = state;
        case (state)
            OCIOSO:    if (enviar) state_next = CALCULA;
            CALCULA:   state_next = RESULTADO;
            RESULTADO: if (valido) state_next = (vitoria || bloqueado) ? FIM : OCIOSO;
            FIM:       state_next = FIM;
            default:   state_next = OCIOSO;
        endcase
        if (novo_jogo) begin
            state_next = OCIOSO;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pronto    <= 1'b1;
            valido    <= 1'b0;
            igual     <= 1'b0;
            perto     <= 1'b0;
            errada    <= 1'b0;
            acima     <= 1'b0;
            distancia <= '0;
            erros     <= '0;
            vitoria   <= 1'b0;
            bloqueado <= 1'b0;
            senha_r   <= '0;
            tent_r    <= '0;
        end else begin
            pronto <= (state_next == OCIOSO);
            valido <= 1'b0;
            if (novo_jogo) begin
                igual     <= 1'b0;
                perto     <= 1'b0;
                errada    <= 1'b0;
                acima     <= 1'b0;
                distancia <= '0;
                erros     <= '0;
                vitoria   <= 1'b0;
                bloqueado <= 1'b0;
            end else begin
                case (state)
                    OCIOSO: begin
                        if (enviar) begin
                            senha_r <= senha;
                            tent_r  <= tentativa;
                        end
                    end
                    CALCULA: begin
                        distancia <= mag;
                        acima     <= positivo;
                    end
                    RESULTADO: begin
                        if (!valido) begin
                            valido <= 1'b1;
                            igual  <= acerto;
                            perto  <= proximo;
                            errada <= !acerto && !proximo;
                            if (acerto) begin
                                vitoria <= 1'b1;
                            end else if (erros != MAX_W) begin
                                erros <= erros_inc;
                                if (erros_inc == MAX_W) begin
                                    bloqueado <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
